bsg_clk_gen_monitor_ctrl: RTL and testbench
===========================================

BSG_CLK_GEN_MONITOR_CTRL -- requirements
Module: bsg_clk_gen_monitor_ctrl

Interface
REQ-001 SHALL have parameter num_clks_p, default 4, number of monitored (divided) clocks, >=2.
REQ-002 SHALL have parameter count_width_p, default 16, width of edge-count result.
REQ-003 SHALL have parameter window_width_p, default 16, width of measurement-window length.
REQ-004 SHALL have parameter settle_cycles_p, default 4, reference cycles discarded after each select change.
REQ-005 clk_i  in  1  reference clock; single clock domain.
REQ-006 reset_i  in  1  reset, asynchronous, active-high.
REQ-007 clk_monitor_i  in  num_clks_p  divided monitor clocks, asynchronous to clk_i.
REQ-008 start_v_i  in  1  measurement request valid.
REQ-009 start_ready_o  out  1  request accepted when start_v_i & start_ready_o.
REQ-010 start_sel_i  in  lg(num_clks_p)  clock index for single mode; ignored in sweep mode.
REQ-011 start_sweep_i  in  1  1 = measure indices 0..num_clks_p-1 in order, one result each.
REQ-012 window_i  in  window_width_p  window length in clk_i cycles.
REQ-013 v_o  out  1  result valid.
REQ-014 ready_i  in  1  result consumed when v_o & ready_i.
REQ-015 count_o  out  count_width_p  rising edges counted in window.
REQ-016 id_o  out  lg(num_clks_p)  index measured.
REQ-017 ovf_o  out  1  count saturated.
REQ-018 last_o  out  1  final result of request (always 1 in single mode).

Function
REQ-019 FSM states SHALL be IDLE, SETTLE, MEASURE, DONE.
REQ-020 start_ready_o SHALL be 1 only in IDLE.
REQ-021 On request acceptance, SHALL latch window_i, sweep bit, and select (start_sel_i, or 0 if sweep), then enter SETTLE.
REQ-022 Selected clock SHALL be muxed, then passed through 2-flop synchronizer, then 1-flop edge-history register; rising edge = sync 1 and history 0.
REQ-023 SETTLE SHALL last exactly settle_cycles_p cycles; edges detected in SETTLE ignored; count cleared.
REQ-024 MEASURE SHALL last exactly latched window cycles, incrementing count by 1 on each cycle with a detected rising edge.
REQ-025 Window of 0 SHALL skip MEASURE: SETTLE -> DONE with count_o=0, ovf_o=0.
REQ-026 Count SHALL saturate at 2^count_width_p-1; any further edge sets ovf_o, count held.
REQ-027 DONE SHALL assert v_o with count_o/id_o/ovf_o/last_o stable until handshake.
REQ-028 On handshake: single mode or last index -> IDLE; sweep with index < num_clks_p-1 -> increment index, enter SETTLE next cycle.
REQ-029 last_o SHALL be 1 in single mode, and in sweep only when id_o = num_clks_p-1.
REQ-030 Result latency, single mode: v_o rises settle_cycles_p + window + 1 cycles after the accept cycle.
REQ-031 start_v_i SHALL be ignored outside IDLE; no queuing.
REQ-032 start_sel_i >= num_clks_p SHALL be clamped to num_clks_p-1.

Reset
REQ-033 reset_i SHALL asynchronously force IDLE, start_ready_o=1 after release, v_o=0, count_o=0, id_o=0, ovf_o=0, last_o=0, synchronizer/history flops 0.
REQ-034 Reset mid-SETTLE/MEASURE/DONE SHALL abort; no partial result produced after release.

Verification
REQ-035 Single, sel=2, window=300, clk_monitor_i[2] period 10 clk_i cycles -> one result, count_o=30 (+/-1), id_o=2, last_o=1, ovf_o=0.
REQ-036 Sweep, window=100, monitor periods 4/8/16/32 cycles -> four results ids 0..3, counts 25/12/6/3 (+/-1), last_o only on id 3.
REQ-037 count_width_p=4, window=200, period 4 -> count_o=15, ovf_o=1.
REQ-038 window=0 -> v_o after settle_cycles_p+1 cycles, count_o=0; ready_i held 0 for 20 cycles -> outputs stable, no second v_o.
REQ-039 reset_i pulsed mid-MEASURE of sweep -> v_o=0 immediately, start_ready_o=1 after release, next request produces correct fresh result.
REQ-040 start_v_i held high during MEASURE with different sel -> ignored; single result with original id_o.

Source files
------------

// File: rtl/bsg_clk_gen_monitor_ctrl.sv
// Frequency monitor: counts rising edges of one selected divided clock over a
// programmable window of reference cycles, optionally sweeping every input clock.
module bsg_clk_gen_monitor_ctrl #(
    parameter int num_clks_p      = 4,
    parameter int count_width_p   = 16,
    parameter int window_width_p  = 16,
    parameter int settle_cycles_p = 4,
    localparam int sel_width_lp   = $clog2(num_clks_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_clks_p-1:0]     clk_monitor_i,
    input  logic                      start_v_i,
    output logic                      start_ready_o,
    input  logic [sel_width_lp-1:0]   start_sel_i,
    input  logic                      start_sweep_i,
    input  logic [window_width_p-1:0] window_i,
    output logic                      v_o,
    input  logic                      ready_i,
    output logic [count_width_p-1:0]  count_o,
    output logic [sel_width_lp-1:0]   id_o,
    output logic                      ovf_o,
    output logic                      last_o,
    output logic [1:0]                state_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int settle_w_lp = $clog2(settle_cycles_p + 1);
    localparam int timer_w_lp  = (window_width_p > settle_w_lp) ? window_width_p : settle_w_lp;

    localparam logic [timer_w_lp-1:0]    settle_init_lp = timer_w_lp'(settle_cycles_p - 1);
    localparam logic [sel_width_lp-1:0]  last_sel_lp    = sel_width_lp'(num_clks_p - 1);
    localparam logic [count_width_p-1:0] count_max_lp   = {count_width_p{1'b1}};

    logic [1:0]                state;
    logic [timer_w_lp-1:0]     timer;
    logic [window_width_p-1:0] window_r;
    logic                      sweep_r;
    logic [sel_width_lp-1:0]   sel_r;
    logic [count_width_p-1:0]  count_r;
    logic                      ovf_r;
    logic                      sync1, sync2, hist;
    logic                      mon_sel;
    logic                      edge_det;
    logic [sel_width_lp-1:0]   sel_clamped;

    assign mon_sel     = clk_monitor_i[sel_r];
    assign edge_det    = sync2 & ~hist;
    assign sel_clamped = (start_sel_i > last_sel_lp) ? last_sel_lp : start_sel_i;

    // Both handshakes are valid/ready: a transfer happens on a cycle where valid
    // and ready are both high; valid-side data is held stable until that cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            timer    <= '0;
            window_r <= '0;
            sweep_r  <= 1'b0;
            sel_r    <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
        end else begin
            sync1 <= mon_sel;
            sync2 <= sync1;
            hist  <= sync2;
            case (state)
                IDLE: begin
                    if (start_v_i) begin
                        window_r <= window_i;
                        sweep_r  <= start_sweep_i;
                        sel_r    <= start_sweep_i ? '0 : sel_clamped;
                        count_r  <= '0;
                        ovf_r    <= 1'b0;
                        timer    <= settle_init_lp;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Synchronizer still holds the previous clock's samples here.
                    if (timer == '0) begin
                        if (window_r == '0) begin
                            state <= DONE;
                        end else begin
                            timer <= timer_w_lp'(window_r - 1'b1);
                            state <= MEASURE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        if (count_r == count_max_lp) ovf_r   <= 1'b1;
                        else                         count_r <= count_r + 1'b1;
                    end
                    if (timer == '0) state <= DONE;
                    else             timer <= timer - 1'b1;
                end
                DONE: begin
                    if (ready_i) begin
                        if (sweep_r && (sel_r != last_sel_lp)) begin
                            sel_r   <= sel_r + 1'b1;
                            count_r <= '0;
                            ovf_r   <= 1'b0;
                            timer   <= settle_init_lp;
                            state   <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready_o = (state == IDLE);
    assign v_o           = (state == DONE);
    assign count_o       = count_r;
    assign id_o          = sel_r;
    assign ovf_o         = ovf_r;
    assign last_o        = (state == DONE) & (~sweep_r | (sel_r == last_sel_lp));
    assign state_o       = state;

endmodule

// File: tb/tb_bsg_clk_gen_monitor_ctrl.sv
// Bench for bsg_clk_gen_monitor_ctrl: expected edge counts come from window/period
// arithmetic on the generated monitor clocks, checked within one edge.
`timescale 1ns/1ps
module tb_bsg_clk_gen_monitor_ctrl;
    localparam int N = 4;
    localparam int S = 4;

    int checks = 0;
    int errors = 0;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // monitor clocks, periods in reference cycles
    int   mon_period [N] = '{4, 8, 16, 32};
    logic mon_bit [N];
    logic [N-1:0] clk_mon;
    for (genvar g = 0; g < N; g++) begin : g_mon
        initial begin
            mon_bit[g] = 1'b0;
            #(2 + 3 * g);
            forever begin
                #(mon_period[g] * 5);
                mon_bit[g] = ~mon_bit[g];
            end
        end
    end
    assign clk_mon = {mon_bit[3], mon_bit[2], mon_bit[1], mon_bit[0]};

    // main DUT
    logic        start_v, start_sweep, ready;
    logic [1:0]  start_sel;
    logic [15:0] window;
    logic        start_ready, v_o, ovf, last;
    logic [15:0] count;
    logic [1:0]  id, state;

    bsg_clk_gen_monitor_ctrl dut (
        .clk_i(clk), .reset_i(reset), .clk_monitor_i(clk_mon),
        .start_v_i(start_v), .start_ready_o(start_ready), .start_sel_i(start_sel),
        .start_sweep_i(start_sweep), .window_i(window), .v_o(v_o), .ready_i(ready),
        .count_o(count), .id_o(id), .ovf_o(ovf), .last_o(last), .state_o(state)
    );

    // narrow-counter DUT for saturation
    logic        start_v_s, start_sweep_s, ready_s;
    logic [1:0]  start_sel_s;
    logic [15:0] window_s;
    logic        start_ready_s, v_s, ovf_s, last_s;
    logic [3:0]  count_s;
    logic [1:0]  id_s, state_s;

    bsg_clk_gen_monitor_ctrl #(.count_width_p(4)) dut_small (
        .clk_i(clk), .reset_i(reset), .clk_monitor_i(clk_mon),
        .start_v_i(start_v_s), .start_ready_o(start_ready_s), .start_sel_i(start_sel_s),
        .start_sweep_i(start_sweep_s), .window_i(window_s), .v_o(v_s), .ready_i(ready_s),
        .count_o(count_s), .id_o(id_s), .ovf_o(ovf_s), .last_o(last_s), .state_o(state_s)
    );

    // reference model: edges expected in a window, saturating
    function automatic int exp_count(input int win, input int period, input int maxv);
        int e;
        e = win / period;
        return (e > maxv) ? maxv : e;
    endfunction

    // driver tasks
    task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
        mon_period[0] = p0; mon_period[1] = p1; mon_period[2] = p2; mon_period[3] = p3;
        repeat (30) @(negedge clk);
    endtask

    task automatic send_req(input int sel, input int sweep, input int win);
        @(negedge clk);
        start_v = 1'b1; start_sel = 2'(sel); start_sweep = sweep[0]; window = 16'(win);
        @(negedge clk);
        start_v = 1'b0;
    endtask

    task automatic wait_v(input int budget, output int n);
        n = 0;
        while (v_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", v_o); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", id); end
        checks++; if (ovf !== 1'b0 || last !== 1'b0) begin errors++; $display("FAIL reset_ovf_last: got %b%b want 00", ovf, last); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", start_ready); end
    endtask

    task automatic test_single();
        int n, c, e;
        set_periods(4, 8, 10, 32);
        send_req(2, 0, 300);
        wait_v(400, n);
        checks++; if (n != S + 300) begin errors++; $display("FAIL single_latency: got %0d want %0d", n + 1, S + 301); end
        e = exp_count(300, 10, 65535); c = int'(count);
        checks++; if ($isunknown(count) || c < e - 1 || c > e + 1) begin errors++; $display("FAIL single_count: got %0d want %0d+/-1", c, e); end
        checks++; if (id !== 2'd2 || last !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL single_flags: got id=%0d last=%b ovf=%b want id=2 last=1 ovf=0", id, last, ovf); end
        handshake();
        checks++; if (v_o !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL single_return_idle: got v=%b rdy=%b want v=0 rdy=1", v_o, start_ready); end
    endtask

    task automatic test_sweep();
        int n, c, e;
        set_periods(4, 8, 16, 32);
        send_req(0, 1, 100);
        for (int i = 0; i < N; i++) begin
            wait_v(300, n);
            checks++; if (n != S + 100) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d want %0d", i, n, S + 100); end
            e = exp_count(100, mon_period[i], 65535); c = int'(count);
            checks++; if ($isunknown(count) || c < e - 1 || c > e + 1) begin errors++; $display("FAIL sweep_count[%0d]: got %0d want %0d+/-1", i, c, e); end
            checks++; if (id !== 2'(i) || last !== (i == N - 1)) begin errors++; $display("FAIL sweep_id_last[%0d]: got id=%0d last=%b want id=%0d last=%b", i, id, last, i, i == N - 1); end
            handshake();
        end
        checks++; if (start_ready !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL sweep_end_idle: got rdy=%b v=%b want 1 0", start_ready, v_o); end
    endtask

    task automatic test_saturation();
        int n;
        set_periods(4, 4, 16, 32);
        @(negedge clk);
        start_v_s = 1'b1; start_sel_s = 2'd1; start_sweep_s = 1'b0; window_s = 16'd200;
        @(negedge clk);
        start_v_s = 1'b0;
        n = 0;
        while (v_s !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++; if (n != S + 200) begin errors++; $display("FAIL sat_latency: got %0d want %0d", n, S + 200); end
        checks++; if (count_s !== 4'(exp_count(200, 4, 15)) || ovf_s !== 1'b1) begin errors++; $display("FAIL sat_count_ovf: got %0d/%b want 15/1", count_s, ovf_s); end
        checks++; if (id_s !== 2'd1 || last_s !== 1'b1) begin errors++; $display("FAIL sat_id_last: got %0d/%b want 1/1", id_s, last_s); end
        ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
        checks++; if (start_ready_s !== 1'b1) begin errors++; $display("FAIL sat_idle: got %b want 1", start_ready_s); end
    endtask

    task automatic test_window_zero();
        int n, bad;
        send_req(3, 0, 0);
        wait_v(50, n);
        checks++; if (n != S) begin errors++; $display("FAIL zero_latency: got %0d want %0d", n + 1, S + 1); end
        checks++; if (count !== 16'd0 || ovf !== 1'b0 || id !== 2'd3 || last !== 1'b1) begin errors++; $display("FAIL zero_result: got c=%0d ovf=%b id=%0d last=%b want 0 0 3 1", count, ovf, id, last); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v_o !== 1'b1 || count !== 16'd0 || id !== 2'd3 || last !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_hold_stable: got %0d unstable cycles want 0", bad); end
        handshake();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (v_o !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_no_second_v: got %0d valid cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_measure();
        int n, c, e;
        set_periods(4, 8, 16, 32);
        send_req(0, 1, 100);
        repeat (S + 20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (v_o !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL rst_abort: got v=%b state=%0d want 0 0", v_o, state); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", start_ready); end
        wait_v(200, n);
        checks++; if (n != 200) begin errors++; $display("FAIL rst_stale_result: got v after %0d cycles want none", n); end
        send_req(1, 0, 80);
        wait_v(200, n);
        checks++; if (n != S + 80) begin errors++; $display("FAIL rst_fresh_latency: got %0d want %0d", n, S + 80); end
        e = exp_count(80, 8, 65535); c = int'(count);
        checks++; if ($isunknown(count) || c < e - 1 || c > e + 1 || id !== 2'd1 || last !== 1'b1) begin errors++; $display("FAIL rst_fresh_result: got c=%0d id=%0d last=%b want %0d+/-1 1 1", c, id, last, e); end
        handshake();
    endtask

    task automatic test_ignore_start();
        int n, c, e;
        set_periods(4, 8, 10, 32);
        send_req(2, 0, 100);
        start_v = 1'b1; start_sel = 2'd0; start_sweep = 1'b1; window = 16'd5;
        wait_v(300, n);
        start_v = 1'b0;
        checks++; if (n != S + 100) begin errors++; $display("FAIL ign_latency: got %0d want %0d", n, S + 100); end
        e = exp_count(100, 10, 65535); c = int'(count);
        checks++; if ($isunknown(count) || c < e - 1 || c > e + 1 || id !== 2'd2 || last !== 1'b1) begin errors++; $display("FAIL ign_result: got c=%0d id=%0d last=%b want %0d+/-1 2 1", c, id, last, e); end
        handshake();
        wait_v(150, n);
        checks++; if (n != 150) begin errors++; $display("FAIL ign_second_result: got v after %0d want none", n); end
    endtask

    task automatic test_random();
        int exp_id_q[$];
        int exp_cnt_q[$];
        int sel, sweep, win, n, c, e, eid;
        for (int it = 0; it < 6; it++) begin
            set_periods($urandom_range(4, 20), $urandom_range(4, 20), $urandom_range(4, 20), $urandom_range(4, 20));
            sel = $urandom_range(0, 3); sweep = $urandom_range(0, 1); win = $urandom_range(20, 160);
            if (sweep != 0) begin
                for (int k = 0; k < N; k++) begin
                    exp_id_q.push_back(k); exp_cnt_q.push_back(exp_count(win, mon_period[k], 65535));
                end
            end else begin
                exp_id_q.push_back(sel); exp_cnt_q.push_back(exp_count(win, mon_period[sel], 65535));
            end
            send_req(sel, sweep, win);
            while (exp_id_q.size() > 0) begin
                eid = exp_id_q.pop_front(); e = exp_cnt_q.pop_front();
                wait_v(400, n);
                checks++; if (n != S + win) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, n, S + win); end
                c = int'(count);
                checks++; if ($isunknown(count) || c < e - 1 || c > e + 1) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d+/-1", it, c, e); end
                checks++; if (id !== 2'(eid) || last !== (sweep == 0 || eid == N - 1)) begin errors++; $display("FAIL rand_id_last[%0d]: got %0d/%b want %0d", it, id, last, eid); end
                handshake();
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        start_v = 1'b0; start_sel = '0; start_sweep = 1'b0; window = '0; ready = 1'b0;
        start_v_s = 1'b0; start_sel_s = '0; start_sweep_s = 1'b0; window_s = '0; ready_s = 1'b0;
        test_reset();
        test_single();
        test_sweep();
        test_saturation();
        test_window_zero();
        test_reset_mid_measure();
        test_ignore_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
